pmul_seq_ctrl: RTL and testbench



---
 rtl/pmul_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pmul_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmul_seq_ctrl.sv
// Sequencer for a 256-bit point-multiply core: loads k/gx/gy word by word,
// starts the core, waits for completion (with optional timeout), and writes the result back.
module pmul_seq_ctrl #(
  parameter int unsigned pWORDS   = 8,
  parameter int unsigned pTIMEOUT = 24'hFFFFFF
) (
  input  logic        crypto_clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] k_word_i,
  input  logic [31:0] gx_word_i,
  input  logic [31:0] gy_word_i,
  output logic [2:0]  k_addr_o,
  output logic [2:0]  gx_addr_o,
  output logic [2:0]  gy_addr_o,
  output logic        core_load_o,
  output logic [2:0]  core_idx_o,
  output logic [31:0] core_k_o,
  output logic [31:0] core_gx_o,
  output logic [31:0] core_gy_o,
  output logic        core_start_o,
  input  logic        core_done_i,
  output logic [2:0]  core_rd_idx_o,
  input  logic [31:0] core_rx_i,
  input  logic [31:0] core_ry_i,
  output logic [2:0]  rx_addr_o,
  output logic [2:0]  ry_addr_o,
  output logic        rx_wren_o,
  output logic        ry_wren_o,
  output logic [31:0] rx_word_o,
  output logic [31:0] ry_word_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] wait_cycles_o
);

  localparam logic [2:0]  LAST_IDX = 3'(pWORDS - 1);
  localparam logic [31:0] TO_LAST  = (pTIMEOUT == 0) ? 32'd0 : 32'(pTIMEOUT - 1);
  localparam bit          TO_EN    = (pTIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LADDR, S_LWR, S_START, S_WAIT, S_UNLOAD, S_FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [31:0] k_reg, k_next;
  logic [31:0] gx_reg, gx_next;
  logic [31:0] gy_reg, gy_next;
  logic [31:0] timer_reg, timer_next;
  logic [31:0] wait_reg, wait_next;
  logic        timeout_reg, timeout_next;

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= 3'd0;
      k_reg       <= 32'd0;
      gx_reg      <= 32'd0;
      gy_reg      <= 32'd0;
      timer_reg   <= 32'd0;
      wait_reg    <= 32'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      k_reg       <= k_next;
      gx_reg      <= gx_next;
      gy_reg      <= gy_next;
      timer_reg   <= timer_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    k_next        = k_reg;
    gx_next       = gx_reg;
    gy_next       = gy_reg;
    timer_next    = timer_reg;
    wait_next     = wait_reg;
    timeout_next  = timeout_reg;

    k_addr_o      = 3'd0;
    gx_addr_o     = 3'd0;
    gy_addr_o     = 3'd0;
    core_load_o   = 1'b0;
    core_idx_o    = 3'd0;
    core_k_o      = 32'd0;
    core_gx_o     = 32'd0;
    core_gy_o     = 32'd0;
    core_start_o  = 1'b0;
    core_rd_idx_o = 3'd0;
    rx_addr_o     = 3'd0;
    ry_addr_o     = 3'd0;
    rx_wren_o     = 1'b0;
    ry_wren_o     = 1'b0;
    rx_word_o     = 32'd0;
    ry_word_o     = 32'd0;
    done_o        = 1'b0;
    busy_o        = (state_reg != S_IDLE);
    ready_o       = (state_reg == S_IDLE);
    timeout_o     = timeout_reg;
    wait_cycles_o = wait_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_next   = S_LADDR;
          idx_next     = 3'd0;
          timeout_next = 1'b0;
          wait_next    = 32'd0;
        end
      end
      S_LADDR: begin
        k_addr_o   = idx_reg;
        gx_addr_o  = idx_reg;
        gy_addr_o  = idx_reg;
        k_next     = k_word_i;
        gx_next    = gx_word_i;
        gy_next    = gy_word_i;
        state_next = S_LWR;
      end
      S_LWR: begin
        core_load_o = 1'b1;
        core_idx_o  = idx_reg;
        core_k_o    = k_reg;
        core_gx_o   = gx_reg;
        core_gy_o   = gy_reg;
        if (idx_reg == LAST_IDX) begin
          state_next = S_START;
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = S_LADDR;
        end
      end
      S_START: begin
        core_start_o = 1'b1;
        timer_next   = 32'd0;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        // A done coinciding with the terminal count takes priority over the timeout.
        if (core_done_i) begin
          idx_next   = 3'd0;
          state_next = S_UNLOAD;
        end else begin
          timer_next = timer_reg + 32'd1;
          wait_next  = (wait_reg == 32'hFFFF_FFFF) ? wait_reg : wait_reg + 32'd1;
          if (TO_EN && (timer_reg == TO_LAST)) begin
            timeout_next = 1'b1;
            state_next   = S_FIN;
          end
        end
      end
      S_UNLOAD: begin
        core_rd_idx_o = idx_reg;
        rx_addr_o     = idx_reg;
        ry_addr_o     = idx_reg;
        rx_wren_o     = 1'b1;
        ry_wren_o     = 1'b1;
        rx_word_o     = core_rx_i;
        ry_word_o     = core_ry_i;
        if (idx_reg == LAST_IDX) begin
          state_next = S_FIN;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      S_FIN: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides whatever the active state chose; timeout and wait count are kept.
    if (abort_i && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      idx_next   = 3'd0;
    end
  end

endmodule

// File: tb/tb_pmul_seq_ctrl.sv
// Self-checking bench for pmul_seq_ctrl: table-driven and randomized transactions
// against a cycle-schedule model, plus abort, reset and timeout corner sequences.
module tb_pmul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start_i, abort_i, core_done_i;
  logic [31:0] k_word, gx_word, gy_word, core_rx, core_ry;
  logic [2:0]  k_addr, gx_addr, gy_addr, core_idx, core_rd_idx, rx_addr, ry_addr;
  logic        core_load, core_start, rx_wren, ry_wren, ready, busy, done, timeout;
  logic [31:0] core_k, core_gx, core_gy, rx_word, ry_word, wait_cycles;

  logic        t_start, t_core_done;
  logic [31:0] t_k_word, t_gx_word, t_gy_word, t_core_rx, t_core_ry;
  logic [2:0]  t_k_addr, t_gx_addr, t_gy_addr, t_core_idx, t_core_rd_idx, t_rx_addr, t_ry_addr;
  logic        t_core_load, t_core_start, t_rx_wren, t_ry_wren, t_ready, t_busy, t_done, t_timeout;
  logic [31:0] t_core_k, t_core_gx, t_core_gy, t_rx_word, t_ry_word, t_wait_cycles;

  logic [31:0] k_mem [8];
  logic [31:0] gx_mem[8];
  logic [31:0] gy_mem[8];
  logic [31:0] rx_mem[8];
  logic [31:0] ry_mem[8];

  // Register block and core result ports are combinational reads.
  assign k_word    = k_mem[k_addr];
  assign gx_word   = gx_mem[gx_addr];
  assign gy_word   = gy_mem[gy_addr];
  assign core_rx   = rx_mem[core_rd_idx];
  assign core_ry   = ry_mem[core_rd_idx];
  assign t_k_word  = k_mem[t_k_addr];
  assign t_gx_word = gx_mem[t_gx_addr];
  assign t_gy_word = gy_mem[t_gy_addr];
  assign t_core_rx = rx_mem[t_core_rd_idx];
  assign t_core_ry = ry_mem[t_core_rd_idx];

  pmul_seq_ctrl dut (
    .crypto_clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .k_word_i(k_word), .gx_word_i(gx_word), .gy_word_i(gy_word),
    .k_addr_o(k_addr), .gx_addr_o(gx_addr), .gy_addr_o(gy_addr),
    .core_load_o(core_load), .core_idx_o(core_idx),
    .core_k_o(core_k), .core_gx_o(core_gx), .core_gy_o(core_gy),
    .core_start_o(core_start), .core_done_i(core_done_i),
    .core_rd_idx_o(core_rd_idx), .core_rx_i(core_rx), .core_ry_i(core_ry),
    .rx_addr_o(rx_addr), .ry_addr_o(ry_addr), .rx_wren_o(rx_wren), .ry_wren_o(ry_wren),
    .rx_word_o(rx_word), .ry_word_o(ry_word),
    .ready_o(ready), .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .wait_cycles_o(wait_cycles)
  );

  pmul_seq_ctrl #(.pTIMEOUT(16)) dut_to (
    .crypto_clk(clk), .reset_n(reset_n), .start_i(t_start), .abort_i(abort_i),
    .k_word_i(t_k_word), .gx_word_i(t_gx_word), .gy_word_i(t_gy_word),
    .k_addr_o(t_k_addr), .gx_addr_o(t_gx_addr), .gy_addr_o(t_gy_addr),
    .core_load_o(t_core_load), .core_idx_o(t_core_idx),
    .core_k_o(t_core_k), .core_gx_o(t_core_gx), .core_gy_o(t_core_gy),
    .core_start_o(t_core_start), .core_done_i(t_core_done),
    .core_rd_idx_o(t_core_rd_idx), .core_rx_i(t_core_rx), .core_ry_i(t_core_ry),
    .rx_addr_o(t_rx_addr), .ry_addr_o(t_ry_addr), .rx_wren_o(t_rx_wren), .ry_wren_o(t_ry_wren),
    .rx_word_o(t_rx_word), .ry_word_o(t_ry_word),
    .ready_o(t_ready), .busy_o(t_busy), .done_o(t_done), .timeout_o(t_timeout),
    .wait_cycles_o(t_wait_cycles)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cy; logic [2:0] idx; logic [31:0] k, gx, gy; } ld_t;
  typedef struct { int cy; logic rxe, rye; logic [2:0] ra, rb, ri; logic [31:0] rw, yw; } wr_t;
  ld_t ld_q[$];
  wr_t wr_q[$];
  int  st_q[$], dn_q[$], t_wr_q[$], t_dn_q[$], t_st_q[$];
  ld_t ld_e;
  wr_t wr_e;

  // Event log, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (core_load) begin
      ld_e.cy = cyc; ld_e.idx = core_idx; ld_e.k = core_k; ld_e.gx = core_gx; ld_e.gy = core_gy;
      ld_q.push_back(ld_e);
    end
    if (rx_wren || ry_wren) begin
      wr_e.cy = cyc; wr_e.rxe = rx_wren; wr_e.rye = ry_wren;
      wr_e.ra = rx_addr; wr_e.rb = ry_addr; wr_e.ri = core_rd_idx;
      wr_e.rw = rx_word; wr_e.yw = ry_word;
      wr_q.push_back(wr_e);
    end
    if (core_start) st_q.push_back(cyc);
    if (done) dn_q.push_back(cyc);
    if (t_rx_wren || t_ry_wren) t_wr_q.push_back(cyc);
    if (t_done) t_dn_q.push_back(cyc);
    if (t_core_start) t_st_q.push_back(cyc);
  end

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endfunction

  task automatic clear_logs();
    ld_q.delete(); wr_q.delete(); st_q.delete(); dn_q.delete();
    t_wr_q.delete(); t_dn_q.delete(); t_st_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction on the default-timeout instance; done arrives d cycles into WAIT.
  task automatic run_op(input int d, input int exp_wait, input int off_start,
                        input int off_wr, input int off_done, input bit spur);
    int t0;
    clear_logs();
    tick();
    t0 = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < t0 + d + 32) begin
      core_done_i = (cyc == t0 + 18 + d);
      start_i     = spur && ((cyc == t0 + 18) || (cyc == t0 + 21 + d));
      tick();
    end
    core_done_i = 1'b0;
    start_i = 1'b0;
    chk("n_loads", ld_q.size(), 8);
    for (int i = 0; i < ld_q.size() && i < 8; i++) begin
      chk("load_cyc", ld_q[i].cy - t0, 2 + 2 * i);
      chk("load_idx", 32'(ld_q[i].idx), i);
      chk("load_k", ld_q[i].k, k_mem[i]);
      chk("load_gx", ld_q[i].gx, gx_mem[i]);
      chk("load_gy", ld_q[i].gy, gy_mem[i]);
    end
    chk("n_starts", st_q.size(), 1);
    if (st_q.size() > 0) chk("start_cyc", st_q[0] - t0, off_start);
    chk("n_writes", wr_q.size(), 8);
    for (int i = 0; i < wr_q.size() && i < 8; i++) begin
      chk("wr_cyc", wr_q[i].cy - t0, off_wr + i);
      chk("wr_en", {30'd0, wr_q[i].rxe, wr_q[i].rye}, 32'd3);
      chk("wr_addr", {23'd0, wr_q[i].ra, wr_q[i].rb, wr_q[i].ri}, {23'd0, 3'(i), 3'(i), 3'(i)});
      chk("wr_rx", wr_q[i].rw, rx_mem[i]);
      chk("wr_ry", wr_q[i].yw, ry_mem[i]);
    end
    chk("n_done", dn_q.size(), 1);
    if (dn_q.size() > 0) chk("done_cyc", dn_q[0] - t0, off_done);
    chk("wait_cycles", wait_cycles, exp_wait);
    chk("timeout_clear", timeout, 0);
    chk("ready_after", ready, 1);
    $display("op d=%0d start@%0d done_events=%0d writes=%0d wait=%0d", d, t0, dn_q.size(), wr_q.size(), wait_cycles);
  endtask

  typedef struct { int d; int exp_wait; int off_start; int off_wr; int off_done; bit spur; } vec_t;
  vec_t vecs[5];

  initial begin
    int t0, d;
    vecs[0] = '{22, 22, 17, 41, 49, 1'b0};
    vecs[1] = '{0, 0, 17, 19, 27, 1'b0};
    vecs[2] = '{1, 1, 17, 20, 28, 1'b0};
    vecs[3] = '{7, 7, 17, 26, 34, 1'b0};
    vecs[4] = '{10, 10, 17, 29, 37, 1'b1};
    for (int i = 0; i < 8; i++) begin
      k_mem[i]  = 32'h1000_0000 + i;
      gx_mem[i] = 32'h2000_0000 + i;
      gy_mem[i] = 32'h3000_0000 + i;
      rx_mem[i] = $urandom;
      ry_mem[i] = $urandom;
    end
    reset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; core_done_i = 1'b0;
    t_start = 1'b0; t_core_done = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {core_load, core_start, rx_wren, ry_wren, done}, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_wait", wait_cycles, 0);
    chk("rst_addr", {k_addr, gx_addr, gy_addr, rx_addr, ry_addr, core_rd_idx, core_idx}, 0);
    chk("rst_data", core_k | core_gx | core_gy | rx_word | ry_word, 0);
    chk("rst_t_timeout", t_timeout, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++)
      run_op(vecs[v].d, vecs[v].exp_wait, vecs[v].off_start, vecs[v].off_wr, vecs[v].off_done, vecs[v].spur);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        k_mem[i] = $urandom; gx_mem[i] = $urandom; gy_mem[i] = $urandom;
        rx_mem[i] = $urandom; ry_mem[i] = $urandom;
      end
      d = $urandom_range(0, 40);
      run_op(d, d, 17, 19 + d, 27 + d, 1'b0);
    end

    // Abort during LWR at idx 3.
    clear_logs();
    tick(); t0 = cyc; start_i = 1'b1;
    tick(); start_i = 1'b0;
    while (cyc < t0 + 8) tick();
    abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    repeat (30) tick();
    chk("abort_no_start", st_q.size(), 0);
    chk("abort_no_done", dn_q.size(), 0);
    $display("abort at LWR idx3: starts=%0d dones=%0d", st_q.size(), dn_q.size());
    run_op(22, 22, 17, 41, 49, 1'b0);

    // Abort together with start in IDLE.
    clear_logs();
    tick(); abort_i = 1'b1; start_i = 1'b1;
    tick(); abort_i = 1'b0; start_i = 1'b0;
    chk("abort_start_idle", ready, 1);
    repeat (3) tick();
    chk("abort_start_no_load", ld_q.size(), 0);
    $display("abort+start in IDLE: loads=%0d", ld_q.size());

    // Reset during UNLOAD at idx 4.
    clear_logs();
    tick(); t0 = cyc; start_i = 1'b1;
    tick(); start_i = 1'b0;
    while (cyc < t0 + 45) begin
      core_done_i = (cyc == t0 + 40);
      tick();
    end
    core_done_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstu_wren", {rx_wren, ry_wren}, 0);
    chk("rstu_data", rx_word | ry_word, 0);
    chk("rstu_addr", {rx_addr, ry_addr, core_rd_idx}, 0);
    chk("rstu_ready", ready, 1);
    chk("rstu_wait", wait_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rstu_writes", wr_q.size(), 4);
    chk("rstu_no_done", dn_q.size(), 0);
    $display("reset in UNLOAD idx4: writes=%0d dones=%0d", wr_q.size(), dn_q.size());

    // Timeout instance: no done at all.
    clear_logs();
    tick(); t0 = cyc; t_start = 1'b1;
    tick(); t_start = 1'b0;
    while (cyc < t0 + 40) tick();
    chk("to_timeout", t_timeout, 1);
    chk("to_n_done", t_dn_q.size(), 1);
    if (t_dn_q.size() > 0) chk("to_done_cyc", t_dn_q[0] - t0, 34);
    chk("to_no_wren", t_wr_q.size(), 0);
    chk("to_wait", t_wait_cycles, 16);
    chk("to_start_cnt", t_st_q.size(), 1);
    $display("timeout op: done_events=%0d writes=%0d timeout=%0b", t_dn_q.size(), t_wr_q.size(), t_timeout);

    // Next start clears timeout; done at the terminal count wins.
    clear_logs();
    tick(); t0 = cyc; t_start = 1'b1;
    tick(); t_start = 1'b0;
    chk("to_clear_on_start", t_timeout, 0);
    chk("to_wait_clear", t_wait_cycles, 0);
    while (cyc < t0 + 50) begin
      t_core_done = (cyc == t0 + 33);
      tick();
    end
    t_core_done = 1'b0;
    chk("race_timeout", t_timeout, 0);
    chk("race_writes", t_wr_q.size(), 8);
    chk("race_n_done", t_dn_q.size(), 1);
    if (t_dn_q.size() > 0) chk("race_done_cyc", t_dn_q[0] - t0, 42);
    chk("race_wait", t_wait_cycles, 15);
    $display("done at terminal count: writes=%0d timeout=%0b", t_wr_q.size(), t_timeout);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
